// File: rtl/onehot_scan_decoder_pkg.sv
// onehot_scan_decoder_pkg: mode encodings and scan direction shared by the scan decoder files.
package onehot_scan_decoder_pkg;
    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_BOUNCE    = 2'b11
    } mode_e;
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;
endpackage

// File: rtl/onehot_scan_decoder_tick_gen.sv
// tick_gen: prescaler counting 0..TICK_DIV-1 while run, pulsing tick on the last count.
module tick_gen
    import onehot_scan_decoder_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);
    logic [CNT_W-1:0] cnt_q;
    assign tick = run && (cnt_q == CNT_W'(TICK_DIV - 1));
    always_ff @(posedge clk_100MHz) begin
        if (reset || clr)
            cnt_q <= '0;
        else if (run)
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
endmodule

// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered one-hot LED driver with direct select and timed scan modes.
// Define ONEHOT_SCAN_BOUNCE_EN to make mode 11 a ping-pong scan; otherwise it acts as DIRECT.
module onehot_scan_decoder
    import onehot_scan_decoder_pkg::*;
#(
    parameter int SEL_W    = 4,
    parameter int TICK_DIV = 10_000_000
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic [SEL_W-1:0]      sw,
    input  logic [1:0]            mode,
    input  logic                  en,
    output logic [2**SEL_W-1:0]   LED,
    output logic [SEL_W-1:0]      pos,
    output logic                  step
);
    localparam int OUT_W = 2**SEL_W;
    mode_e             mode_eff, prev_mode_q;
    logic [SEL_W-1:0]  pos_q, pos_d;
    logic [OUT_W-1:0]  led_q;
    logic              step_q, scan, changed, run, clr, tick;
`ifdef ONEHOT_SCAN_BOUNCE_EN
    dir_e              dir_q, dir_d;
    assign mode_eff = mode_e'(mode);
`else
    assign mode_eff = (mode == MODE_BOUNCE) ? MODE_DIRECT : mode_e'(mode);
`endif
    assign scan    = mode_eff != MODE_DIRECT;
    assign changed = mode_eff != prev_mode_q;
    assign run     = en && scan && !changed;
    assign clr     = en && (!scan || changed);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .run       (run),
        .clr       (clr),
        .tick      (tick)
    );

    always_comb begin
        pos_d = pos_q;
        if (en && (mode_eff == MODE_DIRECT || prev_mode_q == MODE_DIRECT))
            pos_d = sw;
        else if (tick && mode_eff == MODE_SCAN_UP)
            pos_d = pos_q + SEL_W'(1);
        else if (tick && mode_eff == MODE_SCAN_DOWN)
            pos_d = pos_q - SEL_W'(1);
`ifdef ONEHOT_SCAN_BOUNCE_EN
        else if (tick)
            pos_d = (dir_q == DIR_UP) ? ((pos_q == {SEL_W{1'b1}}) ? {SEL_W{1'b1}} - SEL_W'(1) : pos_q + SEL_W'(1))
                                      : ((pos_q == '0) ? SEL_W'(1) : pos_q - SEL_W'(1));
`endif
    end

`ifdef ONEHOT_SCAN_BOUNCE_EN
    // Endpoints flip direction in the same step so each end is shown for one period.
    always_comb begin
        dir_d = dir_q;
        if (en && prev_mode_q == MODE_DIRECT)
            dir_d = DIR_UP;
        else if (en && changed)
            dir_d = (mode_eff == MODE_SCAN_DOWN) ? DIR_DOWN : DIR_UP;
        else if (tick && mode_eff == MODE_BOUNCE)
            dir_d = (dir_q == DIR_UP) ? ((pos_q == {SEL_W{1'b1}}) ? DIR_DOWN : DIR_UP)
                                      : ((pos_q == '0) ? DIR_UP : DIR_DOWN);
    end
    always_ff @(posedge clk_100MHz) begin
        if (reset)
            dir_q <= DIR_UP;
        else
            dir_q <= dir_d;
    end
`endif

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            pos_q       <= '0;
            prev_mode_q <= MODE_DIRECT;
            led_q       <= '0;
            step_q      <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            prev_mode_q <= en ? mode_eff : prev_mode_q;
            led_q       <= en ? (OUT_W'(1) << pos_d) : '0;
            step_q      <= tick;
        end
    end

    assign LED  = led_q;
    assign pos  = pos_q;
    assign step = step_q;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: directed checks of the scan decoder with SEL_W=4, TICK_DIV=4.
module tb_onehot_scan_decoder;
    logic        clk_100MHz = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  sw = 4'd0;
    logic [1:0]  mode = 2'b00;
    logic        en = 1'b1;
    logic [15:0] LED;
    logic [3:0]  pos;
    logic        step;
    int          checks = 0;
    int          failures = 0;

    onehot_scan_decoder #(.SEL_W(4), .TICK_DIV(4)) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .sw        (sw),
        .mode      (mode),
        .en        (en),
        .LED       (LED),
        .pos       (pos),
        .step      (step)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic scan12(input string tag, input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2);
        logic [3:0] e [3];
        logic [3:0] got [3];
        int n;
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int i = 0; i < 3; i++) got[i] = 4'bx;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (step) begin
                if (n < 3) begin
                    got[n] = pos;
                    check({tag, "_led"}, LED, 32'(16'h1 << e[n]));
                end
                n++;
            end
        end
        check({tag, "_steps"}, n, 3);
        for (int i = 0; i < 3; i++) check({tag, "_pos"}, got[i], e[i]);
    endtask

    initial begin
        sw = 4'd9; cyc(); cyc();
        check("rst_led", LED, 0);
        check("rst_pos", pos, 0);
        check("rst_step", step, 0);
        reset = 1'b0; cyc();
        check("direct_led", LED, 16'h0200);
        check("direct_pos", pos, 9);
        check("direct_step", step, 0);

        sw = 4'd14; cyc();
        check("direct14_pos", pos, 14);
        mode = 2'b01; cyc();
        check("up_entry_pos", pos, 14);
        check("up_entry_step", step, 0);
        scan12("up", 4'd15, 4'd0, 4'd1);

        mode = 2'b00; sw = 4'd1; cyc();
        check("direct1_pos", pos, 1);
        mode = 2'b10; cyc();
        check("down_entry_pos", pos, 1);
        scan12("down", 4'd0, 4'd15, 4'd14);

`ifdef ONEHOT_SCAN_BOUNCE_EN
        mode = 2'b00; sw = 4'd14; cyc();
        mode = 2'b11; cyc();
        check("bounce_entry_pos", pos, 14);
        scan12("bounce", 4'd15, 4'd14, 4'd13);
`else
        mode = 2'b11; sw = 4'd5; cyc();
        check("m11_led", LED, 16'h0020);
        check("m11_pos", pos, 5);
        begin
            int n = 0;
            for (int i = 0; i < 8; i++) begin
                cyc();
                if (step) n++;
            end
            check("m11_nosteps", n, 0);
            check("m11_hold_pos", pos, 5);
        end
`endif

        mode = 2'b00; sw = 4'd3; cyc();
        mode = 2'b01; cyc();
        cyc(); cyc();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("hold_led", LED, 0);
            check("hold_pos", pos, 3);
            check("hold_step", step, 0);
        end
        en = 1'b1; cyc();
        check("resume_led", LED, 16'h0008);
        check("resume_step0", step, 0);
        cyc();
        check("resume_step1", step, 1);
        check("resume_pos", pos, 4);

        mode = 2'b00; sw = 4'd7; cyc();
        mode = 2'b01; cyc();
        cyc(); cyc(); cyc();
        reset = 1'b1; cyc();
        check("rst_tick_pos", pos, 0);
        check("rst_tick_led", LED, 0);
        check("rst_tick_step", step, 0);
        reset = 1'b0; cyc();
        check("post_rst_pos", pos, 7);
        check("post_rst_led", LED, 16'h0080);
        cyc(); cyc(); cyc();
        mode = 2'b10; cyc();
        check("chg_tick_step", step, 0);
        check("chg_tick_pos", pos, 7);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("chg_cnt_clear", step, 0);
        end
        cyc();
        check("chg_first_step", step, 1);
        check("chg_first_pos", pos, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
